inst_fetch_ctrl: RTL
====================

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset.
REQ-002 The block SHALL be clocked by clk (input, 1), the single clock; all state updates on posedge clk.
REQ-003 rst (input, 1): reset is synchronous and active-high.
REQ-004 imem_addr (output, 32): byte address to instruction memory; memory read is combinational, same-cycle.
REQ-005 imem_rdata (input, 32): instruction word for imem_addr, valid in the same cycle.
REQ-006 redirect_valid (input, 1): branch/jump redirect request.
REQ-007 redirect_pc (input, 32): redirect target, sampled when redirect_valid=1.
REQ-008 halt_req (input, 1): level request to stop fetching.
REQ-009 out_valid (output, 1): head of fetch queue is valid.
REQ-010 out_ready (input, 1): decode accepts head; pop when out_valid && out_ready.
REQ-011 out_instr (output, 32) and out_pc (output, 32): head entry instruction and its PC.
REQ-012 halted (output, 1): 1 only in state HALTED.

Function
REQ-013 The block SHALL hold a 2-entry FIFO of {pc, instr}; count 0..2.
REQ-014 States SHALL be RUN, DRAIN, HALTED.
REQ-015 Fetch fires in a cycle iff state=RUN, redirect_valid=0, halt_req=0, and (count<2 or pop this cycle).
REQ-016 On fetch: imem_addr=pc, {pc, imem_rdata} pushed, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0).
REQ-017 imem_addr SHALL equal pc in every cycle, fetching or not.
REQ-018 Fetch-to-out_valid latency SHALL be 1 cycle; pushes appear at tail in program order.
REQ-019 Simultaneous push and pop at count=2 or count=1 SHALL leave count unchanged and preserve order.
REQ-020 Pop at count=0 SHALL not occur (out_valid=0); out_instr/out_pc are don't-care when out_valid=0.
REQ-021 redirect_valid SHALL have priority over fetch, pop and halt: queue flushed (count<=0), pc<={redirect_pc[31:2],2'b00}, no fetch that cycle, state unchanged.
REQ-022 A pop coinciding with a redirect SHALL still be treated as accepted by decode; the flush discards the remaining entries.
REQ-023 RUN->DRAIN when halt_req=1 and redirect_valid=0; no fetch in that cycle.
REQ-024 DRAIN->HALTED when count=0 (including count reaching 0 by pop or flush that cycle); DRAIN->RUN if halt_req drops first.
REQ-025 HALTED->RUN when halt_req=0; first fetch occurs the cycle after entering RUN.
REQ-026 pc SHALL be unchanged in DRAIN and HALTED except by redirect.

Reset
REQ-027 On rst=1 at posedge clk: pc<=RESET_PC, count<=0, state<=RUN, out_valid=0, halted=0, imem_addr=RESET_PC.
REQ-028 rst SHALL override every other input, including mid-drain and simultaneous redirect; first fetch occurs in the first cycle with rst=0.

Configuration
REQ-029 With macro FETCH_PERF_EN defined, the block SHALL add outputs perf_fetch_cnt (32) counting fetches and perf_flush_cnt (32) counting redirects that discarded count>0 entries; both reset to 0, wrap at 2^32.
REQ-030 Without FETCH_PERF_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-031 Reset, RESET_PC=0, out_ready=1, memory 0/4/8 = 0, 0x019C06B3, 0x40740 2B3 word at 8 -> out_pc 0,4,8 on consecutive cycles from cycle 2, instr matches memory.
REQ-032 out_ready=0 for 5 cycles -> count saturates at 2, imem_addr holds 8, out_pc stays 0; ready=1 resumes without loss or duplication.
REQ-033 redirect_valid=1, redirect_pc=0x2E with count=2 -> next cycle out_valid=0, imem_addr=0x2C; following cycle out_pc=0x2C.
REQ-034 halt_req=1 with count=2, out_ready=1 -> two pops, halted=1 on third cycle, imem_addr frozen; halt_req=0 -> fetch resumes at frozen PC.
REQ-035 rst asserted in DRAIN with count=1 -> next cycle count=0, state RUN, imem_addr=RESET_PC; with FETCH_PERF_EN, counters read 0.
REQ-036 pc=0xFFFF_FFFC fetch -> next imem_addr=0x0000_0000.

Source files
------------

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-controller bus: instruction memory port, redirect/halt controls and the decode-facing queue head.
// The master modport is the fetch controller and the slave modport is its environment.
interface inst_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_req,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    output halt_req,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: PC register, 2-entry {pc, instr} queue and a RUN/DRAIN/HALTED FSM.
// Optional FETCH_PERF_EN macro adds fetch and flush performance counters.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_fetch_ctrl_if.master    bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  count;
  logic        halted_r;
  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];

  logic pop;
  logic fetch;
  logic drain_empty;
  logic wr_hi;

  assign pop   = (count != 2'd0) && bus.out_ready;
  assign fetch = (state == RUN) && !bus.redirect_valid && !bus.halt_req &&
                 ((count != 2'd2) || pop);

  // Queue is empty after this edge: flushed, already empty, or last entry popped.
  assign drain_empty = bus.redirect_valid || (count == 2'd0) || ((count == 2'd1) && pop);

  // New entry lands in slot 1 only when slot 1 is the tail after any shift.
  assign wr_hi = pop ? (count == 2'd2) : (count == 2'd1);

  assign bus.imem_addr = pc;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_pc    = q_pc[0];
  assign bus.out_instr = q_instr[0];
  assign bus.halted    = halted_r;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge values regardless of ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      count    <= 2'd0;
      state    <= RUN;
      halted_r <= 1'b0;
    end else begin
      if (bus.redirect_valid) begin
        count <= 2'd0;
        pc    <= bus.redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (fetch) pc <= pc + 32'd4;
        case ({fetch, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: ;
        endcase
      end

      // Redirect freezes RUN and HALTED; DRAIN sees the flush as emptying the queue.
      unique case (state)
        RUN: begin
          if (bus.halt_req && !bus.redirect_valid) state <= DRAIN;
        end
        DRAIN: begin
          if (!bus.halt_req) begin
            state <= RUN;
          end else if (drain_empty) begin
            state    <= HALTED;
            halted_r <= 1'b1;
          end
        end
        HALTED: begin
          if (!bus.halt_req && !bus.redirect_valid) begin
            state    <= RUN;
            halted_r <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: queue storage has no reset; count alone decides which slots are
  // meaningful, so stale data is never observed while out_valid is 0.
  always_ff @(posedge clk) begin
    if (pop) begin
      q_pc[0]    <= q_pc[1];
      q_instr[0] <= q_instr[1];
    end
    // A push into slot 0 follows the shift above so it overrides it.
    if (fetch) begin
      if (wr_hi) begin
        q_pc[1]    <= pc;
        q_instr[1] <= bus.imem_rdata;
      end else begin
        q_pc[0]    <= pc;
        q_instr[0] <= bus.imem_rdata;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (fetch) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (bus.redirect_valid && (count != 2'd0)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
